pb_irq_controller: RTL
======================

// Module: pb_irq_controller
//
// PURPOSE
// - Shares the single interrupt/interrupt_ack pair of the kcpsmx core among
//   NUM_SRC external requesters.
// - Latches rising edges into a pending register and masks them with a
//   software-writable mask.
// - Arbitrates by fixed priority and holds the winner in service until
//   software writes EOI.
// - Sits beside the core on the port bus (port_id/out_port/write_strobe/read_strobe).
//   The vector is read back through the in_port mux.
//
// PARAMETERS
// - NUM_SRC        8      number of interrupt sources, legal range 1..8
// - BASE_ADDR      8'hF0  first port address of the 4-register window
// - ACK_TIMEOUT    255    cycles in REQ before abandon (only with PB_IRQ_TIMEOUT_EN)
//
// PORTS
// - clk           in   1        system clock, rising edge
// - reset         in   1        asynchronous, active-high reset
// - irq_src       in   NUM_SRC  raw requests, rising-edge sensitive, synchronous to clk
// - port_id       in   8        core port address
// - write_strobe  in   1        core write strobe, 1 cycle
// - read_strobe   in   1        core read strobe (no read side effects)
// - out_port      in   8        core write data
// - in_port_data  out  8        read data for the core in_port mux (combinational)
// - in_port_sel   out  1        1 when port_id is in BASE_ADDR..BASE_ADDR+3
// - interrupt     out  1        to core interrupt input (registered)
// - interrupt_ack in   1        from core, 1-cycle acknowledge
//
// BEHAVIOUR
// - Register map:
//   - BASE+0 STATUS  RO: pending[NUM_SRC-1:0]; upper bits read 0.
//   - BASE+1 MASK    RW: 1 = enabled.
//   - BASE+2 VECTOR  RO: bit7 = in-service valid, bit6 = timeout flag, bits2:0 = in-service index.
//   - BASE+3 EOI     WO: any write ends service (data ignored). Reads 0.
// - Reset (async): state IDLE; interrupt=0; pending=0; mask=0; vector=0; previous sample of irq_src=0.
// - Edge detect: pending[i] is set on the posedge where irq_src[i]=1 and the previous sample was 0.
//   - A same-cycle set and clear of pending[i] resolves to set.
// - Priority: lowest index wins among (pending & mask).
//   - The winner is chosen on the interrupt_ack cycle, not earlier.
// - FSM:
//   - IDLE -> REQ when |(pending & mask). interrupt goes 1 on the posedge entering REQ.
//     - Latency: interrupt is high 2 posedges after irq_src is first sampled high.
//   - REQ stays while interrupt_ack=0. interrupt is held at 1.
//   - REQ -> IDLE, interrupt=0, if (pending & mask) becomes 0 (source masked before ack).
//     No vector update.
//   - REQ -> SERVICE on interrupt_ack:
//     - vector = {1, timeout, winner}; pending[winner] cleared; interrupt=0 same edge.
//   - SERVICE stays until a write to EOI. New edges keep accumulating in pending.
//     No nesting: interrupt stays 0.
//   - SERVICE -> IDLE on EOI write: vector bit7 cleared, index kept.
//     If pending & mask != 0, REQ is entered on the next cycle.
// - interrupt_ack in IDLE or SERVICE is ignored.
// - EOI write in IDLE or REQ is ignored (except timeout-flag clear, see CONFIGURATION).
// - MASK write takes effect the cycle after write_strobe.
//   - Masked sources still set pending; unmasking later raises the request.
// - Writes to STATUS/VECTOR and to addresses outside the window are ignored.
// - in_port_data = 0 when in_port_sel = 0.
//
// CONFIGURATION
// - PB_IRQ_TIMEOUT_EN defined:
//   - An 8-bit counter runs in REQ. It is cleared on entering REQ.
//   - If it reaches ACK_TIMEOUT with no ack: REQ -> IDLE, interrupt=0, vector bit6 set (sticky).
//     pending is kept, so REQ re-enters next cycle.
//   - bit6 is cleared by an EOI write in any state.
// - PB_IRQ_TIMEOUT_EN undefined:
//   - No counter. REQ waits for ack indefinitely. vector bit6 always 0.
//
// TESTING
// - Reset: hold reset with irq_src=8'hFF.
//   -> interrupt=0, STATUS=00, MASK=00, VECTOR=00. After release the previous sample
//      is 0, so STATUS=FF and interrupt stays 0 (mask=0).
// - Single source: MASK=04, pulse irq_src[2].
//   -> interrupt=1 two edges later.
//   -> ack -> VECTOR=0x82, STATUS=00, interrupt=0.
//   -> EOI -> VECTOR=0x02.
// - Priority: MASK=FF, raise src5, then src1 before ack.
//   -> ack gives VECTOR=0x81, STATUS=0x20.
//   -> EOI -> interrupt=1 again -> ack gives VECTOR=0x85.
// - Mask-withdraw: MASK=08, raise src3, write MASK=00 while in REQ.
//   -> interrupt drops, state IDLE, STATUS=08.
//   -> write MASK=08 -> interrupt=1.
// - Accumulate in service: in SERVICE for src0, pulse src0 and src7.
//   -> interrupt stays 0, STATUS=81.
//   -> EOI -> REQ -> ack gives VECTOR=0x80.
// - PB_IRQ_TIMEOUT_EN with ACK_TIMEOUT=4: raise src0, never ack.
//   -> interrupt low after 4 REQ cycles, VECTOR bit6=1, re-request next cycle.
//   -> EOI clears bit6.

Source files
------------

// File: rtl/pb_irq_controller.sv
// Interrupt controller sharing one interrupt/interrupt_ack pair among NUM_SRC edge-triggered sources.
// Optional acknowledge timeout enabled by defining PB_IRQ_TIMEOUT_EN.
module pb_irq_controller #(
    parameter int unsigned NUM_SRC     = 8,
    parameter logic [7:0]  BASE_ADDR   = 8'hF0,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         port_id,
    input  logic               write_strobe,
    input  logic               read_strobe,
    input  logic [7:0]         out_port,
    output logic [7:0]         in_port_data,
    output logic               in_port_sel,
    output logic               interrupt,
    input  logic               interrupt_ack
);

    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [NUM_SRC-1:0] prev_src;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] masked;
    logic [NUM_SRC-1:0] win_clr;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   vec_idx;
    logic               vec_valid;
    logic               vec_timeout;
    logic [7:0]         offset;
    logic               mask_wr;
    logic               eoi_wr;
    logic               take_ack;
    logic               timeout_hit;
    logic               tmo_expired;
    logic               unused_inputs;

    assign unused_inputs = read_strobe;

    // Port window decode
    always_comb begin
        offset      = 8'(port_id - BASE_ADDR);
        in_port_sel = (offset < 8'd4);
        mask_wr     = write_strobe && in_port_sel && (offset[1:0] == 2'd1);
        eoi_wr      = write_strobe && in_port_sel && (offset[1:0] == 2'd3);
    end

    // Lowest enabled pending index wins
    always_comb begin
        rise    = irq_src & ~prev_src;
        masked  = pending & mask;
        win_idx = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (masked[i]) win_idx = IDX_W'(i);
        end
        win_clr = NUM_SRC'(1) << win_idx;
    end

`ifdef PB_IRQ_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    assign tmo_expired = (tmo_cnt == 8'(ACK_TIMEOUT - 1));

    // Counts cycles spent waiting for acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state != REQ) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= 8'(tmo_cnt + 8'd1);
        end
    end

    // Sticky timeout flag; EOI clears it regardless of state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_timeout <= 1'b0;
        end else if (timeout_hit) begin
            vec_timeout <= 1'b1;
        end else if (eoi_wr) begin
            vec_timeout <= 1'b0;
        end
    end
`else
    localparam int unsigned UNUSED_ACK_TIMEOUT = ACK_TIMEOUT;
    logic [31:0] unused_timeout;

    assign unused_timeout = UNUSED_ACK_TIMEOUT;
    assign tmo_expired    = 1'b0;
    assign vec_timeout    = 1'b0;
`endif

    // Next-state logic; losing the enabled request takes precedence over an ack
    always_comb begin
        state_next  = state;
        take_ack    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (|masked) state_next = REQ;
            end
            REQ: begin
                if (!(|masked)) begin
                    state_next = IDLE;
                end else if (interrupt_ack) begin
                    state_next = SERVICE;
                    take_ack   = 1'b1;
                end else if (tmo_expired) begin
                    state_next  = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi_wr) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        pending_next = (pending & ~(take_ack ? win_clr : '0)) | rise;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= state_next;
            interrupt <= (state_next == REQ);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_src  <= '0;
            pending   <= '0;
            mask      <= '0;
            vec_valid <= 1'b0;
            vec_idx   <= '0;
        end else begin
            prev_src <= irq_src;
            pending  <= pending_next;
            if (mask_wr) mask <= out_port[NUM_SRC-1:0];
            if (take_ack) begin
                vec_valid <= 1'b1;
                vec_idx   <= win_idx;
            end else if ((state == SERVICE) && eoi_wr) begin
                vec_valid <= 1'b0;
            end
        end
    end

    // Register read mux
    always_comb begin
        in_port_data = 8'h00;
        if (in_port_sel) begin
            case (offset[1:0])
                2'd0:    in_port_data = 8'(pending);
                2'd1:    in_port_data = 8'(mask);
                2'd2:    in_port_data = {vec_valid, vec_timeout, 3'b000, vec_idx};
                default: in_port_data = 8'h00;
            endcase
        end
    end

endmodule
